// File: rtl/seq_detect_param.sv
// seq_detect_param: serial N-bit pattern detector with loadable pattern, overlap mode and saturating match counter
module seq_detect_param #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int OVERLAP = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  input  logic             pat_we,
  input  logic [N-1:0]     pat_in,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [N-1:0]     pattern
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);
  logic [N-1:0] hist, pat, nhist;
  logic [FW-1:0] fill, nfill;
  logic hit;
  always_comb begin
    nhist = {hist[N-2:0], x};
    nfill = (fill == FULL) ? fill : fill + 1'b1;
    hit = (nfill == FULL) && (nhist == pat);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      hist <= '0;
      fill <= '0;
      pat <= PATTERN;
      match_cnt <= '0;
      z <= 1'b0;
    end else if (pat_we) begin
      hist <= '0;
      fill <= '0;
      pat <= pat_in;
      match_cnt <= '0;
      z <= 1'b0;
    end else if (en) begin
      hist <= nhist;
      fill <= (hit && OVERLAP == 0) ? '0 : nfill;
      match_cnt <= (hit && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
      z <= hit;
    end else begin
      z <= 1'b0;
    end
  end
  assign pattern = pat;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed scoreboard bench over four parameterisations of seq_detect_param
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic clr, en, x, pat_we;
  logic [3:0] pat_in;
  logic [3:0] z;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;
  logic [3:0] p0, p1, p2, p3;
  int npass = 0;
  int ntotal = 0;
  int nstep = 0;
  logic [3:0] sb[$];
  always #5 clk = ~clk;
  seq_detect_param d0 (.clk(clk), .clr(clr), .en(en), .x(x), .pat_we(pat_we), .pat_in(pat_in), .z(z[0]), .match_cnt(c0), .pattern(p0));
  seq_detect_param #(.OVERLAP(0)) d1 (.clk(clk), .clr(clr), .en(en), .x(x), .pat_we(pat_we), .pat_in(pat_in), .z(z[1]), .match_cnt(c1), .pattern(p1));
  seq_detect_param #(.CNT_W(2)) d2 (.clk(clk), .clr(clr), .en(en), .x(x), .pat_we(pat_we), .pat_in(pat_in), .z(z[2]), .match_cnt(c2), .pattern(p2));
  seq_detect_param #(.PATTERN(4'b0000)) d3 (.clk(clk), .clr(clr), .en(en), .x(x), .pat_we(pat_we), .pat_in(pat_in), .z(z[3]), .match_cnt(c3), .pattern(p3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step(input bit c, input bit e, input bit xv, input bit w, input logic [3:0] pi, input logic [3:0] zexp);
    clr = c;
    en = e;
    x = xv;
    pat_we = w;
    pat_in = pi;
    sb.push_back(zexp);
    @(posedge clk);
    #1;
    nstep++;
    chk($sformatf("z@step%0d", nstep), {28'b0, z}, {28'b0, sb.pop_front()});
  endtask
  task automatic feed(input int n, input logic [31:0] xs, input logic [31:0] z0, input logic [31:0] z1, input logic [31:0] z2, input logic [31:0] z3);
    for (int i = 0; i < n; i++) begin
      int k;
      k = n - 1 - i;
      step(1'b0, 1'b1, xs[k], 1'b0, 4'h0, {z3[k], z2[k], z1[k], z0[k]});
    end
  endtask
  task automatic cnts(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_cnt0"}, {24'b0, c0}, e0);
    chk({tag, "_cnt1"}, {24'b0, c1}, e1);
    chk({tag, "_cnt2"}, {30'b0, c2}, e2);
    chk({tag, "_cnt3"}, {24'b0, c3}, e3);
  endtask
  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000);
    cnts("reset", 0, 0, 0, 0);
    chk("reset_pat0", {28'b0, p0}, 32'hB);
    chk("reset_pat3", {28'b0, p3}, 32'h0);
    feed(16, 32'b0101101100101011, 32'b0000100100000001, 32'b0000100000000001, 32'b0000100100000001, 32'b0);
    cnts("stream", 3, 2, 3, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'b0000);
    cnts("patwe", 0, 0, 0, 0);
    chk("patwe_pat1", {28'b0, p1}, 32'hF);
    chk("patwe_pat3", {28'b0, p3}, 32'hF);
    feed(5, 32'b11111, 32'b00011, 32'b00010, 32'b00011, 32'b00011);
    cnts("ones", 2, 1, 2, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000);
    chk("clr_pat2", {28'b0, p2}, 32'hB);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0111);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0000);
    cnts("gaps", 1, 1, 1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000);
    feed(12, 32'hBBB, 32'h111, 32'h111, 32'h111, 32'h0);
    cnts("sat3", 3, 3, 3, 0);
    feed(8, 32'hBB, 32'h11, 32'h11, 32'h11, 32'h0);
    cnts("sat5", 5, 5, 3, 0);
    feed(3, 32'b101, 32'b0, 32'b0, 32'b0, 32'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000);
    feed(1, 32'b1, 32'b0, 32'b0, 32'b0, 32'b0);
    cnts("midclr", 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000);
    feed(3, 32'b000, 32'b0, 32'b0, 32'b0, 32'b0);
    cnts("zero3", 0, 0, 0, 0);
    feed(1, 32'b0, 32'b0, 32'b0, 32'b0, 32'b1);
    cnts("zero4", 0, 0, 0, 1);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
